// File: rtl/data_mem_arb_pkg.sv
// Shared types and constants for the data memory arbiter.
package data_mem_arb_pkg;

  // State encodings for the sequencing FSM.
  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_ISSUE      = 3'd1;
  localparam logic [2:0] S_RD_CAPTURE = 3'd2;
  localparam logic [2:0] S_WR_WAIT    = 3'd3;
  localparam logic [2:0] S_RESP       = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE       = S_IDLE,
    ST_ISSUE      = S_ISSUE,
    ST_RD_CAPTURE = S_RD_CAPTURE,
    ST_WR_WAIT    = S_WR_WAIT,
    ST_RESP       = S_RESP
  } arb_state_e;

  // Port indices: the core data port and the secondary (debug/DMA) master.
  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_AUX  = 1'b1;

  localparam int STARVE_MAX_DEFAULT = 4;
  localparam int STARVE_W           = 3;

  // One latched memory command.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sign_mask;
  } mem_cmd_t;

endpackage

// File: rtl/data_mem_arb_pick.sv
// Winner select between the two ports plus the anti-starvation counter.
module data_mem_arb_pick
  import data_mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic m0_req,
  input  logic m1_req,
  input  logic grant_en,
  output logic grant_port
);

  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  logic [STARVE_W-1:0] starve_cnt_reg;

  // Port 1 wins when alone, or when port 0 has been favoured STARVE_MAX times in a row.
  always_comb begin
    grant_port = PORT_CORE;
    if (m1_req && (!m0_req || (starve_cnt_reg == STARVE_LIM)))
      grant_port = PORT_AUX;
  end

  // Count consecutive port-0 grants that left port 1 waiting; saturates at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_reg <= '0;
    end else if (grant_en) begin
      if (grant_port == PORT_AUX)
        starve_cnt_reg <= '0;
      else if (m1_req)
        starve_cnt_reg <= (starve_cnt_reg == '1) ? starve_cnt_reg : starve_cnt_reg + 1'b1;
      else
        starve_cnt_reg <= '0;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter and timing sequencer in front of the single-ported data memory.
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_sign_mask,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_sign_mask,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_memread,
  output logic        mem_memwrite,
  output logic [3:0]  mem_sign_mask,
  input  logic [31:0] mem_read_data,
  input  logic        mem_clk_stall,
  output logic        busy
);

  arb_state_e  state_reg, state_next;
  mem_cmd_t    cmd_reg;
  logic        cmd_port_reg;
  logic [31:0] rdata_reg;

  logic        grant_en;
  logic        grant_port;
  mem_cmd_t    port_cmd [2];
  logic [1:0]  port_ack;
  logic [31:0] port_rdata [2];

  assign grant_en = (state_reg == ST_IDLE) && (m0_req || m1_req);

  assign port_cmd[0] = '{we: m0_we, addr: m0_addr, wdata: m0_wdata, sign_mask: m0_sign_mask};
  assign port_cmd[1] = '{we: m1_we, addr: m1_addr, wdata: m1_wdata, sign_mask: m1_sign_mask};

  data_mem_arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .clk        (clk),
    .reset      (reset),
    .m0_req     (m0_req),
    .m1_req     (m1_req),
    .grant_en   (grant_en),
    .grant_port (grant_port)
  );

  // State register, command latch on grant, and read-data capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      cmd_reg      <= '0;
      cmd_port_reg <= PORT_CORE;
      rdata_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (grant_en) begin
        cmd_reg      <= port_cmd[grant_port];
        cmd_port_reg <= grant_port;
      end
      if (state_reg == ST_RD_CAPTURE)
        rdata_reg <= mem_read_data;
    end
  end

  // Next state and memory-side outputs; command fields are driven only while busy.
  always_comb begin
    state_next     = state_reg;
    mem_addr       = '0;
    mem_write_data = '0;
    mem_sign_mask  = '0;
    mem_memread    = 1'b0;
    mem_memwrite   = 1'b0;
    busy           = (state_reg != ST_IDLE);
    if (state_reg != ST_IDLE) begin
      mem_addr       = cmd_reg.addr;
      mem_write_data = cmd_reg.wdata;
      mem_sign_mask  = cmd_reg.sign_mask;
    end
    case (state_reg)
      ST_IDLE: begin
        if (m0_req || m1_req)
          state_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        mem_memread  = ~cmd_reg.we;
        mem_memwrite = cmd_reg.we;
        state_next   = cmd_reg.we ? ST_WR_WAIT : ST_RD_CAPTURE;
      end
      ST_RD_CAPTURE: state_next = ST_RESP;
      // The memory raises stall during the modify/write half; wait it out.
      ST_WR_WAIT: begin
        if (!mem_clk_stall)
          state_next = ST_RESP;
      end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Per-port response: ack only for the latched winner, rdata zero unless a load ack.
  for (genvar gi = 0; gi < 2; gi++) begin : g_resp
    assign port_ack[gi]   = (state_reg == ST_RESP) && (cmd_port_reg == 1'(gi));
    assign port_rdata[gi] = (port_ack[gi] && !cmd_reg.we) ? rdata_reg : '0;
  end

  assign m0_ack   = port_ack[0];
  assign m1_ack   = port_ack[1];
  assign m0_rdata = port_rdata[0];
  assign m1_rdata = port_rdata[1];

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-port arbiter and sequencer in front of the single-ported `data_mem` block. It accepts load/store requests from the core data port (port 0) and from a secondary master (port 1: debug loader/DMA) and serialises them onto the memory command interface. It also sequences the memory's one-cycle read and two-cycle read-modify-write timing, and returns a one-cycle `ack` with read data to the winning requester.

## Interface
- `STARVE_MAX`, default 4: number of consecutive port-0 grants, while port 1 is waiting, after which port 1 wins the next arbitration.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `m0_req`, `m1_req`  in  1  request; held high with fields stable until `ack`.
- `m0_we`, `m1_we`  in  1  1 = store, 0 = load.
- `m0_addr`, `m1_addr`  in  32  byte address.
- `m0_wdata`, `m1_wdata`  in  32  store data.
- `m0_sign_mask`, `m1_sign_mask`  in  4  size/sign code, passed unchanged to memory.
- `m0_ack`, `m1_ack`  out  1  one-cycle completion pulse.
- `m0_rdata`, `m1_rdata`  out  32  load result; valid only while own `ack` is high, 0 otherwise.
- `mem_addr`, `mem_write_data`  out  32  memory command fields.
- `mem_memread`, `mem_memwrite`  out  1  memory strobes.
- `mem_sign_mask`  out  4  memory size/sign code.
- `mem_read_data`  in  32  memory combinational read result.
- `mem_clk_stall`  in  1  memory busy with read-modify-write.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, ISSUE, RD_CAPTURE, WR_WAIT, RESP.
- IDLE with no request: stay in IDLE.
- IDLE with any request: choose the winner, latch its `we/addr/wdata/sign_mask` into command registers and go to ISSUE.
- Arbitration:
  - Only one request: that port wins.
  - Both requesting: port 0 wins unless `starve_cnt == STARVE_MAX`, in which case port 1 wins.
- `starve_cnt` (3 bits, saturating):
  - Increments on a port-0 grant while `m1_req` is high.
  - Clears on any port-1 grant.
  - Clears on a port-0 grant while `m1_req` is low.
- ISSUE: drive `mem_memread = ~we` or `mem_memwrite = we` for exactly this one cycle. Next state is RD_CAPTURE for a load, WR_WAIT for a store.
- RD_CAPTURE: register `mem_read_data` into the response register, then go to RESP.
- WR_WAIT: remain while `mem_clk_stall == 1`. Exit to RESP on the first cycle with `mem_clk_stall == 0`, with a minimum of one cycle in this state.
- RESP:
  - Pulse the winner's `ack` for one cycle.
  - Drive the winner's `rdata` (load) or 0 (store).
  - Return to IDLE.
- `mem_addr`, `mem_sign_mask` and `mem_write_data` hold the latched command from ISSUE through RESP. Strobes are 0 in every state except ISSUE.
- Command fields are 0 in IDLE.
- A requester dropping `req` mid-transaction is a protocol violation. The transaction completes and `ack` still pulses.
- No address decoding: address 0x2000 (LED) and all other addresses pass through unchanged.

## Timing
- Request sampled in IDLE at edge E.
- Load: ISSUE in E+1, RD_CAPTURE in E+2, `ack` in E+3.
- Store, with memory stalling one cycle: ISSUE in E+1, WR_WAIT in E+2..E+3, `ack` in E+4.
- After RESP the arbiter is in IDLE for one cycle, so the minimum spacing between grants is 4 cycles (load) or 5 cycles (store).
- A requester still holding `req` in the cycle after `ack` starts a new transaction.
- Reset:
  - Forces IDLE.
  - Clears `starve_cnt`.
  - Drives all outputs to 0: acks, rdata, strobes, command fields and `busy`.
- Reset mid-transaction: the current transaction is abandoned with no `ack`. A store that reached the memory's write cycle may already be committed.

## Structure
- Package `data_mem_arb_pkg`: state encoding localparams, port index constants `PORT_CORE = 0` and `PORT_AUX = 1`, and the `STARVE_MAX` default.
- Sub-module `data_mem_arb_pick` holds the combinational winner select plus the `starve_cnt` register (with `clk`/`reset`). The FSM and command registers stay in the top.

## Test plan
- Port-0 load, addr 0x10, memory word 0xDEADBEEF, `sign_mask` word -> `mem_memread` high only in E+1; `m0_ack` in E+3 with `m0_rdata = 0xDEADBEEF`.
- Port-1 byte store, 0xA5 to addr 0x21 -> single `mem_memwrite` pulse; `m1_ack` in E+4. A subsequent word read of 0x20 returns 0x0000A500 when the word was 0 beforehand.
- Both ports request simultaneously and continuously -> grant order 0,0,0,0,1,0,0,0,0,1,... with `STARVE_MAX = 4`.
- Port-0 request held across its `ack` -> second ISSUE exactly 2 cycles after the first `ack`; `busy` low for exactly 1 cycle between.
- `reset` asserted in WR_WAIT -> next cycle all outputs 0, state IDLE, no `ack` ever issued for that transaction, `starve_cnt` = 0.
- `m0_req` dropped during RD_CAPTURE -> `m0_ack` still pulses in E+3; port 1 is then granted normally.
